// File: rtl/riscv_apu_wb_buffer.sv
// rtl/riscv_apu_wb_buffer.sv - APU result writeback buffer in front of register-file write port B
module riscv_apu_wb_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FLAG_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  apu_valid_i,
    input  logic [DATA_WIDTH-1:0] apu_result_i,
    input  logic [FLAG_WIDTH-1:0] apu_flags_i,
    input  logic                  apu_fp_i,
    input  logic [5:0]            apu_waddr_i,
    input  logic                  lsu_we_i,
    output logic                  rf_we_o,
    output logic [5:0]            rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  fflags_we_o,
    output logic [FLAG_WIDTH-1:0] fflags_o,
    input  logic [17:0]           read_regs_i,
    input  logic [2:0]            read_regs_valid_i,
    output logic                  read_dep_o,
    input  logic [5:0]            write_reg_i,
    input  logic                  write_reg_valid_i,
    output logic                  write_dep_o,
    output logic                  stall_o,
    output logic                  empty_o,
    output logic                  overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [5:0]            waddr_q [DEPTH];
    logic [5:0]            waddr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_d  [DEPTH];
    logic [FLAG_WIDTH-1:0] flags_q [DEPTH];
    logic [FLAG_WIDTH-1:0] flags_d [DEPTH];
    logic                  fp_q    [DEPTH];
    logic                  fp_d    [DEPTH];

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    cnt_t count_q, count_d;
    logic overflow_q, overflow_d;

    logic has_entries;
    logic full;
    logic pop;
    logic bypass;
    logic push;
    logic drop;
    logic entry_live [DEPTH];

    // Explicit wrap so non-power-of-two depths stay inside the array.
    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p == ptr_t'(DEPTH - 1)) begin
            r = '0;
        end else begin
            r = ptr_t'(p + 1'b1);
        end
        return r;
    endfunction

    always_comb begin
        has_entries = (count_q != '0);
        full        = (count_q == cnt_t'(DEPTH));
        pop         = has_entries && !lsu_we_i;
        bypass      = !has_entries && apu_valid_i && !lsu_we_i;
        push        = apu_valid_i && !bypass && (!full || pop);
        drop        = apu_valid_i && !bypass && full && !pop;
    end

    always_comb begin
        waddr_d    = waddr_q;
        data_d     = data_q;
        flags_d    = flags_q;
        fp_d       = fp_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || drop;
        if (push) begin
            waddr_d[wptr_q] = apu_waddr_i;
            data_d[wptr_q]  = apu_result_i;
            flags_d[wptr_q] = apu_flags_i;
            fp_d[wptr_q]    = apu_fp_i;
            wptr_d          = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (push && !pop) begin
            count_d = cnt_t'(count_q + 1'b1);
        end else if (pop && !push) begin
            count_d = cnt_t'(count_q - 1'b1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                data_q[i]  <= '0;
                flags_q[i] <= '0;
                fp_q[i]    <= 1'b0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            waddr_q    <= waddr_d;
            data_q     <= data_d;
            flags_q    <= flags_d;
            fp_q       <= fp_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Port B mux: bypass only when empty, otherwise strictly from the head.
    always_comb begin
        rf_we_o     = 1'b0;
        rf_waddr_o  = '0;
        rf_wdata_o  = '0;
        fflags_we_o = 1'b0;
        fflags_o    = '0;
        if (bypass) begin
            rf_we_o     = 1'b1;
            rf_waddr_o  = apu_waddr_i;
            rf_wdata_o  = apu_result_i;
            fflags_we_o = apu_fp_i;
            fflags_o    = apu_fp_i ? apu_flags_i : '0;
        end else if (pop) begin
            rf_we_o     = 1'b1;
            rf_waddr_o  = waddr_q[rptr_q];
            rf_wdata_o  = data_q[rptr_q];
            fflags_we_o = fp_q[rptr_q];
            fflags_o    = fp_q[rptr_q] ? flags_q[rptr_q] : '0;
        end
    end

    // The head being written this cycle no longer blocks the issuing instruction.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int off;
            if (i >= int'(rptr_q)) begin
                off = i - int'(rptr_q);
            end else begin
                off = i + DEPTH - int'(rptr_q);
            end
            entry_live[i] = (off < int'(count_q)) && !(pop && (off == 0));
        end
    end

    always_comb begin
        read_dep_o  = 1'b0;
        write_dep_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live[i]) begin
                for (int k = 0; k < 3; k++) begin
                    if (read_regs_valid_i[k] && (read_regs_i[6*k +: 6] == waddr_q[i])) begin
                        read_dep_o = 1'b1;
                    end
                end
                if (write_reg_valid_i && (write_reg_i == waddr_q[i])) begin
                    write_dep_o = 1'b1;
                end
            end
        end
    end

    assign stall_o    = (count_q >= cnt_t'(DEPTH - 2));
    assign empty_o    = !has_entries;
    assign overflow_o = overflow_q;

endmodule
